spsram_fifo_ctrl: RTL

Synchronous FIFO controller that sits directly upstream of spsram_double, the 32x32 single-port SRAM. It turns a valid/ready write stream and a valid/ready read stream into SRAM address, write-enable, chip-enable and output-enable cycles. SRAM read data is captured into a 2-entry output buffer, so the consumer sees a registered, back-pressurable stream.

---
 rtl/spsram_fifo_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/spsram_fifo_ctrl.sv
// FIFO controller in front of a single-port SRAM: arbitrates push writes and
// prefetch reads onto one port and holds read data in a 2-entry output buffer.
module spsram_fifo_ctrl #(
  parameter int unsigned BW_DATA = 32,
  parameter int unsigned BW_ADDR = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [BW_DATA-1:0]   i_wdata,
  input  logic                 i_wvalid,
  output logic                 o_wready,
  output logic [BW_DATA-1:0]   o_rdata,
  output logic                 o_rvalid,
  input  logic                 i_rready,
  output logic [BW_ADDR:0]     o_count,
  output logic [BW_DATA-1:0]   o_sram_data,
  output logic [BW_ADDR-1:0]   o_sram_addr,
  output logic                 o_sram_wen,
  output logic                 o_sram_cen,
  output logic                 o_sram_oen,
  input  logic [BW_DATA-1:0]   i_sram_data
);

  localparam int unsigned DEPTH  = 2 ** BW_ADDR;
  localparam int unsigned BW_CNT = BW_ADDR + 1;

  logic [BW_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [BW_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [BW_ADDR-1:0] addr_q, addr_d;
  logic [BW_CNT-1:0]  count_q, count_d;
  logic               rd_pend_q, rd_pend_d;
  logic [1:0]         obuf_n_q, obuf_n_d;
  logic [BW_DATA-1:0] obuf0_q, obuf0_d;
  logic [BW_DATA-1:0] obuf1_q, obuf1_d;

  logic               pop_c;
  logic               rd_go_c;
  logic               wr_go_c;
  logic               full_c;
  logic [2:0]         occ_c;
  logic [1:0]         n_mid_c;

  // Handshake and port arbitration; a read always wins the single SRAM port.
  always_comb begin
    pop_c    = (obuf_n_q != 2'd0) && i_rready;
    occ_c    = {1'b0, obuf_n_q} + 3'(rd_pend_q) - 3'(pop_c);
    rd_go_c  = (count_q != '0) && (occ_c <= 3'd1);
    full_c   = (count_q == BW_CNT'(DEPTH));
    o_wready = i_rstn && !rd_go_c && !full_c;
    wr_go_c  = i_wvalid && o_wready;
  end

  // SRAM command: address holds its last value on idle cycles.
  always_comb begin
    o_sram_data = i_wdata;
    o_sram_cen  = rd_go_c || wr_go_c;
    o_sram_wen  = wr_go_c;
    o_sram_oen  = rd_go_c;
    o_sram_addr = addr_q;
    if (rd_go_c) begin
      o_sram_addr = rd_ptr_q;
    end else if (wr_go_c) begin
      o_sram_addr = wr_ptr_q;
    end
  end

  // Next-state for pointers, count and the output buffer.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    addr_d    = o_sram_addr;
    count_d   = count_q + BW_CNT'(wr_go_c) - BW_CNT'(rd_go_c);
    rd_pend_d = rd_go_c;
    obuf0_d   = obuf0_q;
    obuf1_d   = obuf1_q;
    n_mid_c   = obuf_n_q - 2'(pop_c);

    if (wr_go_c) begin
      wr_ptr_d = wr_ptr_q + BW_ADDR'(1);
    end
    if (rd_go_c) begin
      rd_ptr_d = rd_ptr_q + BW_ADDR'(1);
    end

    if (pop_c) begin
      obuf0_d = obuf1_q;
    end
    // Returning read data lands in the first slot left free after this pop.
    if (rd_pend_q) begin
      if (n_mid_c == 2'd0) begin
        obuf0_d = i_sram_data;
      end else begin
        obuf1_d = i_sram_data;
      end
    end
    obuf_n_d = n_mid_c + 2'(rd_pend_q);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      obuf_n_q  <= 2'd0;
      obuf0_q   <= '0;
      obuf1_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      obuf_n_q  <= obuf_n_d;
      obuf0_q   <= obuf0_d;
      obuf1_q   <= obuf1_d;
    end
  end

  assign o_rdata  = obuf0_q;
  assign o_rvalid = (obuf_n_q != 2'd0);
  assign o_count  = count_q;

endmodule
